// File: rtl/div_32bit.sv
// Signed 32-bit divider: restoring shift-subtract on operand magnitudes, one quotient
// bit per cycle, sign fix-up in a final cycle. Fixed 33-cycle latency from start to done.
module div_32bit (
    input  logic        clock_i,
    input  logic        clear_ni,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic [63:0] result_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_by_zero_o
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] prem_q, prem_d;
    // Holds the dividend magnitude; its MSB shifts out while quotient bits shift in.
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_n_q, neg_n_d;
    logic        neg_d_q, neg_d_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;
    logic        done_q, done_d;

    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted = {prem_q[31:0], quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        neg_n_d     = neg_n_q;
        neg_d_d     = neg_d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    neg_n_d = dividend_i[31];
                    neg_d_d = divisor_i[31];
                    // 32'h80000000 negates to itself, which is 2^31 read as unsigned.
                    quo_d   = dividend_i[31] ? -dividend_i : dividend_i;
                    dvs_d   = divisor_i[31] ? -divisor_i : divisor_i;
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!diff[32]) begin
                    prem_d = diff;
                    quo_d  = {quo_q[30:0], 1'b1};
                end else begin
                    prem_d = shifted;
                    quo_d  = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                dbz_d = (dvs_q == 32'd0);
                if (dvs_q == 32'd0) begin
                    quotient_d = '1;
                end else begin
                    quotient_d = (neg_n_q ^ neg_d_q) ? -quo_q : quo_q;
                end
                remainder_d = neg_n_q ? -prem_q[31:0] : prem_q[31:0];
                done_d      = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or negedge clear_ni) begin
        if (!clear_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_n_q     <= 1'b0;
            neg_d_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_n_q     <= neg_n_d;
            neg_d_q     <= neg_d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        quotient_o    = quotient_q;
        remainder_o   = remainder_q;
        result_o      = {remainder_q, quotient_q};
        busy_o        = (state_q != StIdle);
        done_o        = done_q;
        div_by_zero_o = dbz_q;
    end

endmodule
